// File: rtl/axi4_lite_xbar_n.sv
// One-master, N-slave AXI4-Lite decoding crossbar with an internal DECERR responder.
// Independent read/write state machines hold the decoded slave for the whole transaction.
module axi4_lite_xbar_n #(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'ha0000048, 32'ha00003f8, 32'h80000000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hfffffff8, 32'hfffffff8, 32'hfff00000}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              m_awaddr,
    input  logic                           m_awvalid,
    output logic                           m_awready,
    input  logic [DATA_W-1:0]              m_wdata,
    input  logic [DATA_W/8-1:0]            m_wstrb,
    input  logic                           m_wvalid,
    output logic                           m_wready,
    output logic [1:0]                     m_bresp,
    output logic                           m_bvalid,
    input  logic                           m_bready,
    input  logic [ADDR_W-1:0]              m_araddr,
    input  logic                           m_arvalid,
    output logic                           m_arready,
    output logic [DATA_W-1:0]              m_rdata,
    output logic [1:0]                     m_rresp,
    output logic                           m_rvalid,
    input  logic                           m_rready,
    output logic [NUM_SLAVES*ADDR_W-1:0]   s_awaddr,
    output logic [NUM_SLAVES*ADDR_W-1:0]   s_araddr,
    output logic [NUM_SLAVES*DATA_W-1:0]   s_wdata,
    output logic [NUM_SLAVES*DATA_W/8-1:0] s_wstrb,
    output logic [NUM_SLAVES-1:0]          s_awvalid,
    output logic [NUM_SLAVES-1:0]          s_wvalid,
    output logic [NUM_SLAVES-1:0]          s_bready,
    output logic [NUM_SLAVES-1:0]          s_arvalid,
    output logic [NUM_SLAVES-1:0]          s_rready,
    input  logic [NUM_SLAVES-1:0]          s_awready,
    input  logic [NUM_SLAVES-1:0]          s_wready,
    input  logic [NUM_SLAVES-1:0]          s_bvalid,
    input  logic [NUM_SLAVES-1:0]          s_arready,
    input  logic [NUM_SLAVES-1:0]          s_rvalid,
    input  logic [NUM_SLAVES*2-1:0]        s_bresp,
    input  logic [NUM_SLAVES*2-1:0]        s_rresp,
    input  logic [NUM_SLAVES*DATA_W-1:0]   s_rdata
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    logic [NUM_SLAVES-1:0] aw_hit;
    logic [NUM_SLAVES-1:0] ar_hit;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;

    wstate_t          wstate_q;
    logic [IDX_W-1:0] wsel_q;
    logic             werr_q;
    logic             aw_done_q;
    logic             w_done_q;
    logic             aw_done_d;
    logic             w_done_d;

    rstate_t          rstate_q;
    logic [IDX_W-1:0] rsel_q;
    logic             rerr_q;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    // Address decode and the broadcast address/data fan-out.
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
        assign aw_hit[gi] = (m_awaddr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
        assign ar_hit[gi] = (m_araddr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
        assign s_awaddr[gi*ADDR_W +: ADDR_W] = m_awaddr;
        assign s_araddr[gi*ADDR_W +: ADDR_W] = m_araddr;
        assign s_wdata[gi*DATA_W +: DATA_W]  = m_wdata;
        assign s_wstrb[gi*STRB_W +: STRB_W]  = m_wstrb;
    end

    // Descending scan so the lowest matching slot is the last assignment and wins.
    always_comb begin
        aw_idx = '0;
        ar_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (aw_hit[i]) aw_idx = IDX_W'(i);
            if (ar_hit[i]) ar_idx = IDX_W'(i);
        end
    end

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = m_bvalid & m_bready;
    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid & m_rready;

    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q | w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            wsel_q    <= '0;
            werr_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (m_awvalid) begin
                        wsel_q    <= aw_idx;
                        werr_q    <= ~|aw_hit;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        wstate_q  <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) wstate_q <= W_RESP;
                end
                W_RESP: begin
                    if (b_hs) wstate_q <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rsel_q   <= '0;
            rerr_q   <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (m_arvalid) begin
                        rsel_q   <= ar_idx;
                        rerr_q   <= ~|ar_hit;
                        rstate_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs) rstate_q <= R_DATA;
                end
                R_DATA: begin
                    if (r_hs) rstate_q <= R_IDLE;
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // Write-side routing; done flags gate ready so a channel never handshakes twice.
    always_comb begin
        s_awvalid = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        case (wstate_q)
            W_ADDR: begin
                if (werr_q) begin
                    m_awready = ~aw_done_q;
                    m_wready  = ~w_done_q;
                end else begin
                    s_awvalid[wsel_q] = m_awvalid & ~aw_done_q;
                    s_wvalid[wsel_q]  = m_wvalid & ~w_done_q;
                    m_awready         = s_awready[wsel_q] & ~aw_done_q;
                    m_wready          = s_wready[wsel_q] & ~w_done_q;
                end
            end
            W_RESP: begin
                if (werr_q) begin
                    m_bvalid = 1'b1;
                    m_bresp  = 2'b11;
                end else begin
                    m_bvalid         = s_bvalid[wsel_q];
                    m_bresp          = s_bvalid[wsel_q] ? s_bresp[wsel_q*2 +: 2] : 2'b00;
                    s_bready[wsel_q] = m_bready;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rresp   = 2'b00;
        m_rdata   = '0;
        case (rstate_q)
            R_ADDR: begin
                if (rerr_q) begin
                    m_arready = 1'b1;
                end else begin
                    s_arvalid[rsel_q] = m_arvalid;
                    m_arready         = s_arready[rsel_q];
                end
            end
            R_DATA: begin
                if (rerr_q) begin
                    m_rvalid = 1'b1;
                    m_rresp  = 2'b11;
                end else begin
                    m_rvalid         = s_rvalid[rsel_q];
                    m_rresp          = s_rvalid[rsel_q] ? s_rresp[rsel_q*2 +: 2] : 2'b00;
                    m_rdata          = s_rvalid[rsel_q] ? s_rdata[rsel_q*DATA_W +: DATA_W] : '0;
                    s_rready[rsel_q] = m_rready;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_xbar_n.sv
// Bench for axi4_lite_xbar_n: directed scenarios then random traffic against a
// reference memory/decoder model, with latency-programmable behavioural slaves.
`timescale 1ns/1ps
module tb_axi4_lite_xbar_n;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] m_awaddr, m_araddr;
    logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp, m_rresp;
    logic [NS*AW-1:0] s_awaddr, s_araddr;
    logic [NS*DW-1:0] s_wdata, s_rdata;
    logic [NS*4-1:0]  s_wstrb;
    logic [NS-1:0]    s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [NS-1:0]    s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [NS*2-1:0]  s_bresp, s_rresp;

    axi4_lite_xbar_n dut (
        .clk(clk), .rst(rst),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_araddr(s_araddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_rready(s_rready),
        .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
        .s_arready(s_arready), .s_rvalid(s_rvalid),
        .s_bresp(s_bresp), .s_rresp(s_rresp), .s_rdata(s_rdata)
    );

    // Each slave answers with its own response code so misrouted responses show up.
    function automatic logic [1:0] slv_resp(input int i);
        return (i == 2) ? 2'b01 : 2'b00;
    endfunction

    int aw_lat[NS], w_lat[NS], b_lat[NS], ar_lat[NS], r_lat[NS];
    int aw_cnt[NS], w_cnt[NS], b_cnt[NS], ar_cnt[NS], r_cnt[NS];
    logic got_aw[NS], got_w[NS], r_pend[NS];
    logic [31:0] sw_addr[NS], sw_data[NS], rd_word[NS];
    logic [3:0]  sw_strb[NS];
    logic [31:0] smem[NS][64];
    time aw_t[NS], w_t[NS];

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_awready[i] = s_awvalid[i] && !got_aw[i] && (aw_cnt[i] >= aw_lat[i]);
            s_wready[i]  = s_wvalid[i] && !got_w[i] && (w_cnt[i] >= w_lat[i]);
            s_bvalid[i]  = got_aw[i] && got_w[i] && (b_cnt[i] >= b_lat[i]);
            s_bresp[i*2 +: 2] = s_bvalid[i] ? slv_resp(i) : 2'b00;
            s_arready[i] = s_arvalid[i] && !r_pend[i] && (ar_cnt[i] >= ar_lat[i]);
            s_rvalid[i]  = r_pend[i] && (r_cnt[i] >= r_lat[i]);
            s_rresp[i*2 +: 2]   = s_rvalid[i] ? slv_resp(i) : 2'b00;
            s_rdata[i*DW +: DW] = s_rvalid[i] ? rd_word[i] : 32'h0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (rst) begin
                got_aw[i] <= 1'b0; got_w[i] <= 1'b0; r_pend[i] <= 1'b0;
                aw_cnt[i] <= 0; w_cnt[i] <= 0; b_cnt[i] <= 0; ar_cnt[i] <= 0; r_cnt[i] <= 0;
                for (int j = 0; j < 64; j++) smem[i][j] <= 32'h0;
            end else begin
                if (s_awvalid[i] && s_awready[i]) begin
                    got_aw[i] <= 1'b1; aw_cnt[i] <= 0; aw_t[i] <= $time;
                    sw_addr[i] <= s_awaddr[i*AW +: AW];
                end else if (s_awvalid[i]) aw_cnt[i] <= aw_cnt[i] + 1;
                if (s_wvalid[i] && s_wready[i]) begin
                    got_w[i] <= 1'b1; w_cnt[i] <= 0; w_t[i] <= $time;
                    sw_data[i] <= s_wdata[i*DW +: DW]; sw_strb[i] <= s_wstrb[i*4 +: 4];
                end else if (s_wvalid[i]) w_cnt[i] <= w_cnt[i] + 1;
                if (got_aw[i] && got_w[i]) begin
                    if (s_bvalid[i] && s_bready[i]) begin
                        got_aw[i] <= 1'b0; got_w[i] <= 1'b0; b_cnt[i] <= 0;
                        for (int b = 0; b < 4; b++)
                            if (sw_strb[i][b]) smem[i][sw_addr[i][7:2]][b*8 +: 8] <= sw_data[i][b*8 +: 8];
                    end else b_cnt[i] <= b_cnt[i] + 1;
                end
                if (s_arvalid[i] && s_arready[i]) begin
                    r_pend[i] <= 1'b1; r_cnt[i] <= 0; ar_cnt[i] <= 0;
                    rd_word[i] <= smem[i][s_araddr[i*AW+2 +: 6]];
                end else if (s_arvalid[i]) ar_cnt[i] <= ar_cnt[i] + 1;
                if (r_pend[i]) begin
                    if (s_rvalid[i] && s_rready[i]) r_pend[i] <= 1'b0;
                    else r_cnt[i] <= r_cnt[i] + 1;
                end
            end
        end
    end

    int mon_awv[NS] = '{default: 0};
    int mon_arv[NS] = '{default: 0};
    int mon_bpulse = 0;
    int mon_multi  = 0;
    logic prev_bv = 1'b0;
    always begin
        @(negedge clk);
        #2;
        for (int i = 0; i < NS; i++) begin
            if (s_awvalid[i]) mon_awv[i] <= mon_awv[i] + 1;
            if (s_arvalid[i]) mon_arv[i] <= mon_arv[i] + 1;
        end
        prev_bv <= m_bvalid;
        if (m_bvalid && !prev_bv) mon_bpulse <= mon_bpulse + 1;
        if ($countones(s_awvalid) > 1 || $countones(s_wvalid) > 1 || $countones(s_bready) > 1 ||
            $countones(s_arvalid) > 1 || $countones(s_rready) > 1)
            mon_multi <= mon_multi + 1;
    end

    int total = 0;
    int bad = 0;
    int snap_awv[NS], snap_arv[NS], snap_bp;
    bit [31:0] ref_mem [bit [31:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < NS; i++) begin
            snap_awv[i] = mon_awv[i];
            snap_arv[i] = mon_arv[i];
        end
        snap_bp = mon_bpulse;
    endtask

    function automatic logic [NS-1:0] awv_mask();
        logic [NS-1:0] m = '0;
        for (int i = 0; i < NS; i++) m[i] = (mon_awv[i] != snap_awv[i]);
        return m;
    endfunction

    function automatic logic [NS-1:0] arv_mask();
        logic [NS-1:0] m = '0;
        for (int i = 0; i < NS; i++) m[i] = (mon_arv[i] != snap_arv[i]);
        return m;
    endfunction

    // Reference address map: first matching region, in slave order.
    function automatic int ref_decode(input logic [31:0] a);
        if ((a & 32'hfff00000) == 32'h80000000) return 0;
        if ((a & 32'hfffffff8) == 32'ha00003f8) return 1;
        if ((a & 32'hfffffff8) == 32'ha0000048) return 2;
        return -1;
    endfunction

    function automatic logic [1:0] ref_resp(input logic [31:0] a);
        int s = ref_decode(a);
        return (s < 0) ? 2'b11 : slv_resp(s);
    endfunction

    function automatic logic [NS-1:0] ref_mask(input logic [31:0] a);
        int s = ref_decode(a);
        logic [NS-1:0] m = '0;
        if (s >= 0) m[s] = 1'b1;
        return m;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        bit [31:0] v;
        if (ref_decode(a) < 0) return;
        v = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        for (int b = 0; b < 4; b++) if (st[b]) v[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[a] = v;
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_decode(a) < 0) return 32'h0;
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Called at a falling edge; returns at the falling edge after the B handshake.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            input int wdly, input int bdly, output logic [1:0] resp,
                            output int aw_cyc, output int first_sav, output logic [NS-1:0] sav,
                            output logic stable, output int bv_cycles, output logic ok);
        int t;
        logic aw_ok, w_ok, done;
        logic [1:0] r0;
        m_awaddr = a; m_wdata = d; m_wstrb = st; m_awvalid = 1'b1; m_wvalid = 1'b0;
        t = 0; aw_ok = 0; w_ok = 0; aw_cyc = -1; first_sav = -1; sav = '0;
        while (!(aw_ok && w_ok) && t < 200) begin
            if (!w_ok && t >= wdly) m_wvalid = 1'b1;
            #1;
            if (first_sav < 0 && s_awvalid != '0) begin first_sav = t; sav = s_awvalid; end
            if (m_awvalid && m_awready) begin aw_ok = 1; aw_cyc = t; end
            if (m_wvalid && m_wready) w_ok = 1;
            @(negedge clk); t++;
            if (aw_ok) m_awvalid = 1'b0;
            if (w_ok) m_wvalid = 1'b0;
        end
        done = 0; stable = 1; bv_cycles = 0; resp = 2'bxx; r0 = 2'b00;
        while (!done && t < 400) begin
            #1;
            if (m_bvalid) begin
                if (bv_cycles == 0) r0 = m_bresp;
                else if (m_bresp !== r0) stable = 0;
                bv_cycles++;
                if (bv_cycles > bdly) begin m_bready = 1'b1; resp = m_bresp; done = 1; end
            end
            @(negedge clk); t++;
        end
        m_bready = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
        ok = aw_ok && w_ok && done;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                           output int ar_cyc, output int rv_cyc, output logic ok);
        int t;
        logic ar_ok, done;
        m_araddr = a; m_arvalid = 1'b1;
        t = 0; ar_ok = 0; done = 0; ar_cyc = -1; rv_cyc = -1; data = 32'hx; resp = 2'bxx;
        while (!ar_ok && t < 200) begin
            #1;
            if (m_arready) begin ar_ok = 1; ar_cyc = t; end
            @(negedge clk); t++;
            if (ar_ok) m_arvalid = 1'b0;
        end
        while (!done && t < 400) begin
            #1;
            if (m_rvalid) begin
                rv_cyc = t; m_rready = 1'b1; data = m_rdata; resp = m_rresp; done = 1;
            end
            @(negedge clk); t++;
        end
        m_rready = 1'b0; m_arvalid = 1'b0;
        ok = ar_ok && done;
    endtask

    task automatic set_lat(input int lo, input int hi);
        for (int i = 0; i < NS; i++) begin
            aw_lat[i] = $urandom_range(hi, lo); w_lat[i] = $urandom_range(hi, lo);
            b_lat[i]  = $urandom_range(hi, lo); ar_lat[i] = $urandom_range(hi, lo);
            r_lat[i]  = $urandom_range(hi, lo);
        end
    endtask

    logic [1:0] resp, rresp2;
    logic [31:0] rd, a, d;
    logic [3:0] st;
    logic [NS-1:0] sav;
    logic stab, ok, ok2;
    int awc, fsav, bvc, arc, rvc;
    time wend, rend;

    initial begin
        rst = 1'b1;
        m_awaddr = '0; m_awvalid = 0; m_wdata = '0; m_wstrb = '0; m_wvalid = 0; m_bready = 0;
        m_araddr = '0; m_arvalid = 0; m_rready = 0;
        set_lat(0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs_zero", {m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rresp,
            m_rdata, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait SRAM write then read back.
        snap();
        do_write(32'h80000010, 32'hdeadbeef, 4'hf, 0, 0, resp, awc, fsav, sav, stab, bvc, ok);
        ref_write(32'h80000010, 32'hdeadbeef, 4'hf);
        chk("sram_wr_done", ok, 1);
        chk("sram_awvalid_cycle", fsav, 1);
        chk("sram_awvalid_vec", sav, 3'b001);
        chk("sram_bresp", resp, 2'b00);
        do_read(32'h80000010, rd, resp, arc, rvc, ok);
        chk("sram_rd_done", ok, 1);
        chk("sram_rdata", rd, ref_read(32'h80000010));
        chk("sram_rresp", resp, 2'b00);
        chk("sram_arvalid_vec", arv_mask(), 3'b001);

        // UART write with W arriving three cycles after AW.
        snap();
        do_write(32'ha00003f8, 32'hcafef00d, 4'hf, 3, 0, resp, awc, fsav, sav, stab, bvc, ok);
        ref_write(32'ha00003f8, 32'hcafef00d, 4'hf);
        chk("uart_wr_done", ok, 1);
        chk("uart_bresp", resp, 2'b00);
        chk("uart_awvalid_only_slave1", awv_mask(), 3'b010);
        chk("uart_one_bvalid_pulse", mon_bpulse - snap_bp, 1);
        chk("uart_aw_before_w", aw_t[1] < w_t[1], 1);

        // Unmapped read answered by the error responder.
        snap();
        do_read(32'h00001000, rd, resp, arc, rvc, ok);
        chk("err_rd_done", ok, 1);
        chk("err_arready_cycle", arc, 1);
        chk("err_rvalid_cycle", rvc, 2);
        chk("err_rresp", resp, 2'b11);
        chk("err_rdata", rd, 32'h0);
        chk("err_no_arvalid", arv_mask(), 3'b000);

        // Unmapped write: accepted in the first address cycle, DECERR response.
        do_write(32'h90000000, 32'h11111111, 4'hf, 0, 2, resp, awc, fsav, sav, stab, bvc, ok);
        chk("err_wr_aw_cycle", awc, 1);
        chk("err_bresp", resp, 2'b11);
        chk("err_bvalid_held", bvc, 3);

        // Concurrent SRAM write and slow CLINT read.
        do_write(32'ha0000048, 32'h12345678, 4'hf, 0, 0, resp, awc, fsav, sav, stab, bvc, ok);
        ref_write(32'ha0000048, 32'h12345678, 4'hf);
        chk("clint_bresp", resp, slv_resp(2));
        r_lat[2] = 4;
        snap();
        fork
            begin
                do_write(32'h80000000, 32'h0badf00d, 4'hf, 0, 0, resp, awc, fsav, sav, stab, bvc, ok);
                wend = $time;
            end
            begin
                do_read(32'ha0000048, rd, rresp2, arc, rvc, ok2);
                rend = $time;
            end
        join
        ref_write(32'h80000000, 32'h0badf00d, 4'hf);
        r_lat[2] = 0;
        chk("conc_both_done", {ok, ok2}, 2'b11);
        chk("conc_write_first", wend < rend, 1);
        chk("conc_bresp", resp, 2'b00);
        chk("conc_rresp", rresp2, slv_resp(2));
        chk("conc_rdata", rd, ref_read(32'ha0000048));
        chk("conc_awvalid_vec", awv_mask(), 3'b001);
        chk("conc_arvalid_vec", arv_mask(), 3'b100);

        // Back-pressured B channel, then an immediate next write.
        do_write(32'h80000020, 32'h55aa55aa, 4'hf, 0, 5, resp, awc, fsav, sav, stab, bvc, ok);
        ref_write(32'h80000020, 32'h55aa55aa, 4'hf);
        chk("bp_bresp_stable", stab, 1);
        chk("bp_bvalid_cycles", bvc, 6);
        do_write(32'h80000024, 32'h01020304, 4'hf, 0, 0, resp, awc, fsav, sav, stab, bvc, ok);
        ref_write(32'h80000024, 32'h01020304, 4'hf);
        chk("bp_next_aw_cycle", awc, 1);

        // Reset after AW accepted but before W.
        m_awaddr = 32'h80000008; m_awvalid = 1'b1; m_wdata = 32'hffffffff; m_wstrb = 4'hf;
        @(negedge clk);
        #1;
        chk("rst_aw_accept", m_awready, 1);
        @(negedge clk);
        m_awvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_wvalid = 1'b1;
        #1;
        chk("rst_outputs_zero", {m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rresp,
            m_rdata, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 64'h0);
        @(negedge clk);
        m_wvalid = 1'b0;
        ref_mem.delete();
        do_write(32'h80000004, 32'ha5a55a5a, 4'b0101, 0, 0, resp, awc, fsav, sav, stab, bvc, ok);
        ref_write(32'h80000004, 32'ha5a55a5a, 4'b0101);
        chk("post_rst_wr", {ok, resp}, {1'b1, 2'b00});
        do_read(32'h80000004, rd, resp, arc, rvc, ok);
        chk("post_rst_rdata", rd, ref_read(32'h80000004));

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            set_lat(0, 3);
            case ($urandom_range(3, 0))
                0: a = 32'h80000000 + 4 * $urandom_range(63, 0);
                1: a = 32'ha00003f8 + 4 * $urandom_range(1, 0);
                2: a = 32'ha0000048 + 4 * $urandom_range(1, 0);
                default: begin
                    case ($urandom_range(3, 0))
                        0: a = 32'h00001000;
                        1: a = 32'ha0000050;
                        2: a = 32'ha00003f0;
                        default: a = 32'h90000000;
                    endcase
                end
            endcase
            snap();
            if ($urandom_range(1, 0) == 1) begin
                d = $urandom;
                st = 4'($urandom_range(15, 1));
                do_write(a, d, st, $urandom_range(3, 0), $urandom_range(2, 0),
                         resp, awc, fsav, sav, stab, bvc, ok);
                ref_write(a, d, st);
                chk("rnd_wr", {ok, resp, awv_mask()}, {1'b1, ref_resp(a), ref_mask(a)});
            end else begin
                do_read(a, rd, resp, arc, rvc, ok);
                chk("rnd_rd", {ok, resp, arv_mask(), rd}, {1'b1, ref_resp(a), ref_mask(a), ref_read(a)});
            end
        end

        repeat (2) @(negedge clk);
        chk("select_onehot", mon_multi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_xbar_n.md
# axi4_lite_xbar_n

One-master, N-slave AXI4-Lite decoding crossbar between the bus arbiter and the memory-mapped slaves (SRAM, UART, CLINT, and later slaves). It generalises the fixed three-slave crossbar with a parametrised address map. It adds independent read and write channel state machines that latch the slave selection for the whole transaction. Unmapped accesses complete with DECERR from an internal error responder instead of hanging the bus.

## Interface
- NUM_SLAVES, 3, number of slave ports, 1..16
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- SLV_BASE, {32'ha0000048, 32'ha00003f8, 32'h80000000}, flat NUM_SLAVES*ADDR_W vector; slot i holds slave i base
- SLV_MASK, {32'hfffffff8, 32'hfffffff8, 32'hfff00000}, flat vector; slave i hits when (addr & mask_i) == base_i

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- m_awaddr/m_awvalid/m_awready  in/in/out  ADDR_W/1/1  master write address
- m_wdata/m_wstrb/m_wvalid/m_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  master write data
- m_bresp/m_bvalid/m_bready  out/out/in  2/1/1  master write response
- m_araddr/m_arvalid/m_arready  in/in/out  ADDR_W/1/1  master read address
- m_rdata/m_rresp/m_rvalid/m_rready  out/out/out/in  DATA_W/2/1/1  master read data
- s_awaddr, s_araddr  out  NUM_SLAVES*ADDR_W  per-slave address; all slots carry the master address
- s_wdata/s_wstrb  out  NUM_SLAVES*DATA_W / NUM_SLAVES*DATA_W/8  broadcast write data
- s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready  out  NUM_SLAVES  per-slave handshake; at most one bit set per vector
- s_awready, s_wready, s_bvalid, s_arready, s_rvalid  in  NUM_SLAVES  per-slave handshake
- s_bresp, s_rresp  in  NUM_SLAVES*2  per-slave response
- s_rdata  in  NUM_SLAVES*DATA_W  per-slave read data

## Operation
- Decode: compare the address against all slots. On overlapping hits, the lowest index wins. No hit selects the internal error responder (ERR).
- Write FSM: W_IDLE -> W_ADDR -> W_RESP -> W_IDLE.
  - W_IDLE: m_awready=0 and m_wready=0. When m_awvalid=1, register the decoded index wsel, set aw_done=0 and w_done=0, and go to W_ADDR.
  - W_ADDR: s_awvalid[wsel]=m_awvalid & ~aw_done and s_wvalid[wsel]=m_wvalid & ~w_done. Route m_awready and m_wready from slave wsel. Set each done flag on its handshake. AW and W complete in either order or in the same cycle. Go to W_RESP in the cycle both are done, counting a handshake in the current cycle.
  - ERR in W_ADDR: m_awready=m_wready=1 for each channel not yet done. No slave valid asserts.
  - W_RESP: m_bvalid/m_bresp come from s_bvalid[wsel]/s_bresp[wsel], and s_bready[wsel]=m_bready. ERR drives m_bvalid=1 and m_bresp=2'b11. Go to W_IDLE on m_bvalid & m_bready.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE. Same structure as the write FSM with a single address channel and rsel.
  - ERR returns m_rdata=0 and m_rresp=2'b11.
  - Go to R_IDLE on m_rvalid & m_rready.
- The read and write FSMs run fully independently. A concurrent read and write may target the same slave, and each slave handles its own channel ordering.
- At most one outstanding transaction per direction.
- m_awaddr/m_araddr must stay stable while valid (AXI rule). wsel/rsel never change outside W_IDLE/R_IDLE.
- Out of transaction, all s_*valid, s_*ready and m_*ready outputs are 0. m_rdata and m_bresp are 0 whenever m_rvalid/m_bvalid is 0.

## Timing
- Reset: both FSMs go to IDLE. aw_done, w_done and the sel registers clear. All outputs are 0 in the cycle after rst is sampled high.
- Reset mid-transaction abandons the transaction. Slave-side cleanup is the slaves' own reset.
- Decode latency is 1 cycle. The earliest AW handshake is the cycle after m_awvalid first rises in IDLE.
- Minimum write with zero-wait slaves: 3 cycles (IDLE, ADDR, RESP). Minimum read: 3 cycles. A new transaction in the same direction is accepted the cycle after the response handshake.
- ERR write: AW/W accepted in the first W_ADDR cycle. Then m_bvalid=1 the next cycle and holds until m_bready.
- The response mux is combinational from slave inputs in W_RESP/R_DATA. There are no extra cycles on the response path.
- No combinational path from m_*valid to m_*ready in IDLE.

## Test plan
- Write 0x80000010 data 0xdeadbeef strb 0xf, zero-wait SRAM -> s_awvalid=3'b001 exactly 1 cycle after m_awvalid; m_bresp=2'b00. A read back from 0x80000010 returns 0xdeadbeef with s_arvalid=3'b001.
- Write 0xa00003f8 with m_wvalid arriving 3 cycles after m_awvalid -> UART receives AW then W in order; exactly one m_bvalid pulse; s_awvalid[2] and s_awvalid[0] stay 0 throughout.
- Read 0x00001000 (unmapped) -> m_arready=1 in cycle 2, m_rvalid=1 in cycle 3 with m_rresp=2'b11 and m_rdata=0; no s_arvalid bit ever set.
- Concurrent write to 0x80000000 and read of 0xa0000048 with CLINT 4-cycle rvalid delay -> both complete; the write response returns before the read response; no cross-routing between slaves.
- m_bready held 0 for 5 cycles after s_bvalid -> m_bvalid held with a stable bresp; a new AW is not accepted until 1 cycle after the b handshake.
- rst asserted in W_ADDR after AW accepted but before W -> next cycle all outputs 0 and FSM in W_IDLE; a following write to 0x80000004 completes normally.
